// File: rtl/matrix_result_streamer.sv
// Serialises one packed N x N result matrix into a tagged element stream.
// Element [0][0] sits in the MSBs of mat_data; emission is row- or column-major.
//
// state | meaning
// IDLE  | no matrix held, ready to capture
// SEND  | holding a matrix, presenting one element per beat
module matrix_result_streamer #(
  parameter int ELEM_W = 32,
  parameter int N      = 3,
  parameter int IDX_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mat_valid,
  output logic                  mat_ready,
  input  logic [N*N*ELEM_W-1:0] mat_data,
  input  logic                  col_major,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ELEM_W-1:0]     out_data,
  output logic [IDX_W-1:0]      out_row,
  output logic [IDX_W-1:0]      out_col,
  output logic                  out_last,
  output logic                  busy
);

  localparam int NN    = N * N;
  localparam int CNT_W = $clog2(NN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NN - 1);
  localparam logic [IDX_W-1:0] MAX_IDX   = IDX_W'(N - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state, state_nxt;
  logic [NN*ELEM_W-1:0]  hold_q;
  logic                  cm_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      row_q, col_q;
  logic                  load, adv, at_last;

  assign at_last = (state == SEND) && (cnt_q == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mat_ready = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    adv       = 1'b0;
    case (state)
      IDLE: begin
        mat_ready = 1'b1;
        if (mat_valid) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          adv = 1'b1;
          if (at_last) begin
            // The last transfer frees the holding register in the same cycle.
            mat_ready = 1'b1;
            if (mat_valid) load = 1'b1;
            else           state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Row/column tags are tracked directly so no divider is needed for k/N, k%N.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      cm_q   <= 1'b0;
      cnt_q  <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else if (load) begin
      hold_q <= mat_data;
      cm_q   <= col_major;
      cnt_q  <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else if (adv && !at_last) begin
      cnt_q <= cnt_q + 1'b1;
      if (cm_q) begin
        if (row_q == MAX_IDX) begin
          row_q <= '0;
          col_q <= col_q + 1'b1;
        end else begin
          row_q <= row_q + 1'b1;
        end
      end else begin
        if (col_q == MAX_IDX) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    if (state == SEND) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if (row_q == IDX_W'(r) && col_q == IDX_W'(c))
            out_data = hold_q[(NN-1-(r*N+c))*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  assign out_row  = (state == SEND) ? row_q : '0;
  assign out_col  = (state == SEND) ? col_q : '0;
  assign out_last = at_last;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Bench for matrix_result_streamer: directed and random matrices checked
// against a queue of expected beats built from the element ordering rules.
module tb_matrix_result_streamer;
  localparam int ELEM_W = 32;
  localparam int N      = 3;
  localparam int IDX_W  = 4;

  typedef struct {
    logic [ELEM_W-1:0] d;
    logic [IDX_W-1:0]  r;
    logic [IDX_W-1:0]  c;
  } beat_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  mat_valid, mat_ready, col_major;
  logic [N*N*ELEM_W-1:0] mat_data;
  logic                  out_valid, out_ready, out_last, busy;
  logic [ELEM_W-1:0]     out_data;
  logic [IDX_W-1:0]      out_row, out_col;

  matrix_result_streamer #(.ELEM_W(ELEM_W), .N(N), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .mat_valid(mat_valid), .mat_ready(mat_ready), .mat_data(mat_data),
    .col_major(col_major),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [ELEM_W-1:0] src [N][N];
  beat_t exp_q [$];
  logic  last_accept;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [N*N*ELEM_W-1:0] pack_src();
    logic [N*N*ELEM_W-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        v[(N*N-1-(r*N+c))*ELEM_W +: ELEM_W] = src[r][c];
    return v;
  endfunction

  task automatic fill_src(input int base);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        src[r][c] = ELEM_W'(base + r*N + c);
  endtask

  task automatic push_matrix(input logic cm);
    beat_t b;
    for (int k = 0; k < N*N; k++) begin
      b.r = cm ? IDX_W'(k % N) : IDX_W'(k / N);
      b.c = cm ? IDX_W'(k / N) : IDX_W'(k % N);
      b.d = src[b.r][b.c];
      exp_q.push_back(b);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_mat_ready", mat_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_row", out_row, '0);
    chk("rst_out_col", out_col, '0);
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic step(input logic mv, input logic cm, input logic ordy);
    logic exp_mr;
    beat_t b;
    @(negedge clk);
    mat_valid = mv;
    col_major = cm;
    out_ready = ordy;
    mat_data  = pack_src();
    #1;
    exp_mr = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
    chk("mat_ready", mat_ready, exp_mr);
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("busy", busy, exp_q.size() != 0);
    chk("out_last", out_last, exp_q.size() == 1);
    if (exp_q.size() != 0) begin
      b = exp_q[0];
      chk("out_data", out_data, b.d);
      chk("out_row", out_row, b.r);
      chk("out_col", out_col, b.c);
    end
    last_accept = mv && exp_mr;
    if (ordy && exp_q.size() != 0) void'(exp_q.pop_front());
    if (last_accept) push_matrix(cm);
  endtask

  task automatic send(input logic cm);
    int n = 0;
    do begin
      step(1'b1, cm, 1'b1);
      n++;
    end while (!last_accept && n < 40);
    if (!last_accept) chk("send_timeout", 1'b1, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step(1'b0, 1'b0, 1'b1);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic pend, pcm;
    int n;
    rst_n = 1'b0; mat_valid = 1'b0; col_major = 1'b0; out_ready = 1'b0;
    mat_data = '0; last_accept = 1'b0;
    fill_src(1);
    #1;
    chk_reset_outputs();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // row-major then column-major of 1..9
    send(1'b0); drain();
    send(1'b1); drain();

    // backpressure on the 4th beat
    send(1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    drain();

    // back-to-back with mat_valid held high
    send(1'b0);
    fill_src(101);
    send(1'b0);
    drain();

    // blocked upstream with random backpressure, column-major
    fill_src(1);
    send(1'b1);
    fill_src(201);
    n = 0;
    do begin
      step(1'b1, 1'b1, 1'($urandom_range(0, 1)));
      n++;
    end while (!last_accept && n < 60);
    if (!last_accept) chk("blocked_timeout", 1'b1, 1'b0);
    drain();

    // random matrices, orders, valid and ready
    pend = 1'b0; pcm = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            src[r][c] = $urandom;
        pcm  = 1'($urandom_range(0, 1));
        pend = 1'b1;
      end
      step(pend, pend ? pcm : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      if (last_accept) pend = 1'b0;
    end
    drain();

    // reset mid-frame after 5 transfers
    fill_src(51);
    send(1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    exp_q.delete();
    @(posedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    fill_src(11);
    send(1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
